// File: rtl/exec_datapath_pkg.sv
// rtl/exec_datapath_pkg.sv - shared opcodes, widths and flag indices for the 13-bit datapath
package exec_datapath_pkg;

  localparam int DATA_W = 13;
  localparam int ADDR_W = 3;
  localparam int NREG   = 2 ** ADDR_W;

  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_AND  = 4'b0011;
  localparam logic [3:0] OP_OR   = 4'b0100;
  localparam logic [3:0] OP_XOR  = 4'b0101;
  localparam logic [3:0] OP_SLL  = 4'b0110;
  localparam logic [3:0] OP_SRL  = 4'b0111;
  localparam logic [3:0] OP_SLT  = 4'b1000;
  localparam logic [3:0] OP_MOV  = 4'b1001;
  localparam logic [3:0] OP_RSV0 = 4'b1010;
  localparam logic [3:0] OP_RSV1 = 4'b1011;
  localparam logic [3:0] OP_BEQ  = 4'b1100;
  localparam logic [3:0] OP_BNE  = 4'b1101;
  localparam logic [3:0] OP_BLT  = 4'b1110;
  localparam logic [3:0] OP_JMP  = 4'b1111;

  // Bit positions inside o_flags = {zero, carry, overflow}
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Shift counts at or above the data width flush the operand to zero
  localparam logic [3:0] SHAMT_MAX = 4'd13;

  // Only the ALU opcodes ADD..MOV commit a result to the register file
  function automatic logic is_write_op(input logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_MOV);
  endfunction

endpackage

// File: rtl/exec_datapath_regfile_2r1w.sv
// rtl/exec_datapath_regfile_2r1w.sv - 8x13 register file, two async reads, debug read, one sync write
module regfile_2r1w
  import exec_datapath_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  logic [DATA_W-1:0] regs [NREG];

  // Reset clears every entry; writes to R0 are dropped so it stays zero
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (we && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  // Asynchronous reads; R0 is forced to zero regardless of storage
  always_comb begin
    rdata1   = (raddr1   == '0) ? '0 : regs[raddr1];
    rdata2   = (raddr2   == '0) ? '0 : regs[raddr2];
    dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];
  end

endmodule

// File: rtl/exec_datapath.sv
// rtl/exec_datapath.sv - operand latches, ALU, flags and branch decision for the control unit
module exec_datapath
  import exec_datapath_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  i_opcode,
  input  logic [2:0]  i_destination,
  input  logic [2:0]  i_addr1,
  input  logic [2:0]  i_addr2,
  input  logic [4:0]  i_branch,
  input  logic        i_memRead,
  input  logic        i_memWrite,
  output logic        o_checkbranch,
  output logic [12:0] o_result,
  output logic [2:0]  o_flags,
  output logic [4:0]  o_branch_off,
  input  logic [2:0]  i_dbg_addr,
  output logic [12:0] o_dbg_data
);

  localparam int MSB = DATA_W - 1;

  logic [DATA_W-1:0] rd1, rd2;
  logic [DATA_W-1:0] a_q, b_q;
  logic [3:0]        op_q;
  logic [ADDR_W-1:0] dest_q;

  logic [DATA_W-1:0] alu_f;
  logic              alu_c, alu_v;
  logic [DATA_W:0]   sum, diff;
  logic [2:0]        flags_next;
  logic              rf_we;

  // Branch opcodes and the reserved/no-op codes never reach the write port
  assign rf_we = i_memWrite && is_write_op(op_q);

  regfile_2r1w u_rf (
    .clk      (clk),
    .reset    (reset),
    .we       (rf_we),
    .waddr    (dest_q),
    .wdata    (alu_f),
    .raddr1   (i_addr1),
    .rdata1   (rd1),
    .raddr2   (i_addr2),
    .rdata2   (rd2),
    .dbg_addr (i_dbg_addr),
    .dbg_data (o_dbg_data)
  );

  // ALU over the latched operands; carry/overflow only meaningful for ADD and SUB
  always_comb begin
    alu_f = '0;
    alu_c = 1'b0;
    alu_v = 1'b0;
    sum   = {1'b0, a_q} + {1'b0, b_q};
    diff  = {1'b0, a_q} - {1'b0, b_q};
    case (op_q)
      OP_ADD: begin
        alu_f = sum[DATA_W-1:0];
        alu_c = sum[DATA_W];
        alu_v = (a_q[MSB] == b_q[MSB]) && (alu_f[MSB] != a_q[MSB]);
      end
      OP_SUB: begin
        alu_f = diff[DATA_W-1:0];
        alu_c = diff[DATA_W];
        alu_v = (a_q[MSB] != b_q[MSB]) && (alu_f[MSB] != a_q[MSB]);
      end
      OP_AND: alu_f = a_q & b_q;
      OP_OR:  alu_f = a_q | b_q;
      OP_XOR: alu_f = a_q ^ b_q;
      OP_SLL: alu_f = (b_q[3:0] >= SHAMT_MAX) ? '0 : (a_q << b_q[3:0]);
      OP_SRL: alu_f = (b_q[3:0] >= SHAMT_MAX) ? '0 : (a_q >> b_q[3:0]);
      OP_SLT: alu_f = {{(DATA_W-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
      OP_MOV: alu_f = a_q;
      default: alu_f = '0;
    endcase
    flags_next         = '0;
    flags_next[FLAG_Z] = (alu_f == '0);
    flags_next[FLAG_C] = alu_c;
    flags_next[FLAG_V] = alu_v;
  end

  // Writeback uses the operands latched earlier, then the new fetch overwrites them on the same edge
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= OP_NOP;
      dest_q       <= '0;
      o_result     <= '0;
      o_flags      <= '0;
      o_branch_off <= '0;
    end else begin
      if (i_memWrite) begin
        o_result <= alu_f;
        o_flags  <= flags_next;
      end
      if (i_memRead) begin
        a_q          <= rd1;
        b_q          <= rd2;
        op_q         <= i_opcode;
        dest_q       <= i_destination;
        o_branch_off <= i_branch;
      end
    end
  end

  // Branch decision straight from the live read ports so it is ready the cycle after decode
  always_comb begin
    o_checkbranch = 1'b0;
    case (i_opcode)
      OP_BEQ:  o_checkbranch = (rd1 == rd2);
      OP_BNE:  o_checkbranch = (rd1 != rd2);
      OP_BLT:  o_checkbranch = ($signed(rd1) < $signed(rd2));
      OP_JMP:  o_checkbranch = 1'b1;
      default: o_checkbranch = 1'b0;
    endcase
  end

endmodule
